// File: rtl/scroll_ctrl_pkg.sv
// Shared constants, state encoding, row payload and popcount helper for the scroll sequencer.
package scroll_ctrl_pkg;

    localparam int unsigned ROW_W         = 7;
    localparam int unsigned LAYER_COUNT   = 5;
    localparam int unsigned SCROLL_MS_DEF = 150;
    localparam int unsigned LFSR_W        = 16;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GEN    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    typedef struct packed {
        logic [0:ROW_W-1] map;
        logic [0:ROW_W-1] typ;
        logic [0:ROW_W-1] bonus;
    } row_t;

    localparam row_t FALLBACK_ROW = '{map: 7'b0011100, typ: 7'b0011100, bonus: 7'b0000000};

    function automatic int unsigned row_popcount(input logic [0:ROW_W-1] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/scroll_ctrl_row_gen.sv
// Free-running 16-bit Galois LFSR and the candidate top row derived from it each cycle.
module scroll_ctrl_row_gen
    import scroll_ctrl_pkg::*;
#(
    parameter int unsigned        MIN_BLOCKS = 2,
    parameter logic [LFSR_W-1:0]  SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    output row_t cand_c_o,
    output logic cand_ok_c_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // A stuck-at-zero register would never recover, so reload the seed
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_POLY;
        end
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        cand_c_o.map   = lfsr_q[6:0];
        cand_c_o.typ   = lfsr_q[13:7];
        cand_c_o.bonus = lfsr_q[6:0] & lfsr_q[15:9] & lfsr_q[12:6];
    end

    assign cand_ok_c_o = (row_popcount(lfsr_q[6:0]) >= MIN_BLOCKS);

endmodule

// File: rtl/scroll_ctrl.sv
// Row-scroll sequencer between the game FSM and the five playfield layers.
// Optional SCROLL_CTRL_PENDING_EN queues one request that arrives while busy.
module scroll_ctrl
    import scroll_ctrl_pkg::*;
#(
    parameter int unsigned       SCROLL_MS  = SCROLL_MS_DEF,
    parameter int unsigned       MIN_BLOCKS = 2,
    parameter int unsigned       MAX_TRIES  = 8,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             one_ms_tick,
    input  logic             scroll_req,
    output logic             scroll_busy,
    output logic             layer_load,
    output logic             layer_start,
    output logic             scroll_done,
    output logic [0:ROW_W-1] new_map,
    output logic [0:ROW_W-1] new_type,
    output logic [0:ROW_W-1] new_bonus,
    output logic [15:0]      rows_scrolled
);

    localparam int unsigned TICK_W = $clog2(SCROLL_MS + 1);
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

    state_e            state_q, state_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              settle_q, settle_d;
    logic              busy_q, busy_d;
    logic              load_q, load_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    row_t              row_q, row_d;
    logic [15:0]       rows_q, rows_d;
    logic              pend_q, pend_d;

    row_t              cand;
    logic              cand_ok;

    scroll_ctrl_row_gen #(
        .MIN_BLOCKS (MIN_BLOCKS),
        .SEED       (SEED)
    ) u_row_gen (
        .clk         (clk),
        .rst         (rst),
        .cand_c_o    (cand),
        .cand_ok_c_o (cand_ok)
    );

    always_comb begin
        state_d  = state_q;
        try_d    = try_q;
        tick_d   = tick_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        load_d   = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        row_d    = row_q;
        rows_d   = rows_q;
        pend_d   = 1'b0;
`ifdef SCROLL_CTRL_PENDING_EN
        pend_d   = pend_q | (scroll_req & busy_q);
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (scroll_req) begin
                    state_d = ST_GEN;
                    try_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            // Try budget is checked before the candidate, so the fallback costs one extra cycle
            ST_GEN: begin
                if (try_q == TRY_W'(MAX_TRIES)) begin
                    row_d   = FALLBACK_ROW;
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                end else if (cand_ok) begin
                    row_d   = cand;
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                end else begin
                    try_d   = try_q + 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_START;
                start_d = 1'b1;
            end
            ST_START: begin
                tick_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (one_ms_tick) begin
                    if (tick_q == TICK_W'(SCROLL_MS - 1)) begin
                        settle_d = 1'b0;
                        state_d  = ST_SETTLE;
                    end else begin
                        tick_d   = tick_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rows_d  = (rows_q == 16'hFFFF) ? rows_q : rows_q + 1'b1;
                end else begin
                    settle_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
`ifdef SCROLL_CTRL_PENDING_EN
                if (pend_q || scroll_req) begin
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    try_d   = '0;
                    state_d = ST_GEN;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            try_q    <= '0;
            tick_q   <= '0;
            settle_q <= 1'b0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            row_q    <= '0;
            rows_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            try_q    <= try_d;
            tick_q   <= tick_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
            start_q  <= start_d;
            done_q   <= done_d;
            row_q    <= row_d;
            rows_q   <= rows_d;
            pend_q   <= pend_d;
        end
    end

    assign scroll_busy   = busy_q;
    assign layer_load    = load_q;
    assign layer_start   = start_q;
    assign scroll_done   = done_q;
    assign new_map       = row_q.map;
    assign new_type      = row_q.typ;
    assign new_bonus     = row_q.bonus;
    assign rows_scrolled = rows_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl: default instance plus a forced-fallback instance.
module tb_scroll_ctrl;

    localparam int MS = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_a, req_a, busy_a, load_a, start_a, done_a;
    logic [0:6]  map_a, type_a, bonus_a;
    logic [15:0] rows_a;
    logic        tick_b, req_b, busy_b, load_b, start_b, done_b;
    logic [0:6]  map_b, type_b, bonus_b;
    logic [15:0] rows_b;

    scroll_ctrl #(.SCROLL_MS(150), .MIN_BLOCKS(2), .MAX_TRIES(8), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .one_ms_tick(tick_a), .scroll_req(req_a),
        .scroll_busy(busy_a), .layer_load(load_a), .layer_start(start_a), .scroll_done(done_a),
        .new_map(map_a), .new_type(type_a), .new_bonus(bonus_a), .rows_scrolled(rows_a));

    scroll_ctrl #(.SCROLL_MS(4), .MIN_BLOCKS(7), .MAX_TRIES(8), .SEED(16'h0080)) dut_b (
        .clk(clk), .rst(rst), .one_ms_tick(tick_b), .scroll_req(req_b),
        .scroll_busy(busy_b), .layer_load(load_b), .layer_start(start_b), .scroll_done(done_b),
        .new_map(map_b), .new_type(type_b), .new_bonus(bonus_b), .rows_scrolled(rows_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] map;
        logic [6:0] typ;
        logic [6:0] bonus;
        logic [7:0] lat;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ticks = 0;
    int          last_cyc = -100;
    bit          tick_en = 1'b0;
    bit          counting = 1'b0;
    logic [15:0] m_lfsr_a, m_lfsr_b;

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] l, input logic [15:0] seed);
        if (l == 16'h0000) return seed;
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Reference LFSRs stepping alongside the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr_a <= 16'hACE1;
            m_lfsr_b <= 16'h0080;
        end else begin
            m_lfsr_a <= lfsr_nxt(m_lfsr_a, 16'hACE1);
            m_lfsr_b <= lfsr_nxt(m_lfsr_b, 16'h0080);
        end
    end

    // l0 is the LFSR value in the cycle the request is accepted
    function automatic exp_t predict(input logic [15:0] l0, input logic [15:0] seed, input int min_b);
        exp_t        e;
        logic [15:0] l;
        bit          found;
        e = '0;
        found = 1'b0;
        l = lfsr_nxt(l0, seed);
        for (int t = 0; t < 8; t++) begin
            if (!found && $countones(l[6:0]) >= min_b) begin
                e.map   = l[6:0];
                e.typ   = l[13:7];
                e.bonus = l[6:0] & l[15:9] & l[12:6];
                e.lat   = 8'(2 + t);
                found   = 1'b1;
            end
            l = lfsr_nxt(l, seed);
        end
        if (!found) begin
            e.map   = 7'b0011100;
            e.typ   = 7'b0011100;
            e.bonus = 7'b0000000;
            e.lat   = 8'd10;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick_a = tick_en && (cyc % 10 == 0);
        if (tick_a && counting) begin
            ticks++;
            if (ticks == MS) last_cyc = cyc;
        end
    endtask

    task automatic run_scroll(input string tag, input int rc, input int abort_at, input bit pend);
        exp_t e;
        int   n;
        int   bad;
        n = 0;
        while (load_a !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_load_seen"}, 32'(load_a), 32'd1);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
        chk({tag, "_lat"}, 32'(cyc - rc), 32'(e.lat));
        chk({tag, "_map"}, 32'(map_a), 32'(e.map));
        chk({tag, "_type"}, 32'(type_a), 32'(e.typ));
        chk({tag, "_bonus"}, 32'(bonus_a), 32'(e.bonus));
        chk({tag, "_bonus_subset"}, 32'(bonus_a & ~map_a), 32'd0);
        chk({tag, "_load_no_start"}, 32'(start_a), 32'd0);
        step();
        chk({tag, "_start"}, 32'({start_a, load_a}), 32'b10);
        counting = 1'b1;
        ticks = 0;
        last_cyc = -100;
        bad = 0;
        n = 0;
        while (done_a !== 1'b1 && n < 3000 && !(abort_at > 0 && ticks >= abort_at)) begin
            step();
            n++;
            if (pend) req_a = (ticks == 20 || ticks == 40);
            if (busy_a !== 1'b1 || load_a !== 1'b0 || start_a !== 1'b0) bad++;
        end
        counting = 1'b0;
        if (abort_at == 0) begin
            chk({tag, "_done"}, 32'(done_a), 32'd1);
            chk({tag, "_done_lat"}, 32'(cyc), 32'(last_cyc + 3));
            chk({tag, "_ticks"}, 32'(ticks), 32'(MS));
            chk({tag, "_wait_quiet"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   rc;
        int   n;
        int   bad;
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick_a = 1'b0;
        tick_b = 1'b0;
        #12;
        chk("rst_ctrl", 32'({busy_a, load_a, start_a, done_a}), 32'd0);
        chk("rst_row", 32'({map_a, type_a, bonus_a}), 32'd0);
        chk("rst_rows", 32'(rows_a), 32'd0);
        chk("rst_lfsr", 32'(dut_a.u_row_gen.lfsr_q), 32'h0000ACE1);
        @(negedge clk);
        rst = 1'b0;

        // Forced fallback on the second instance
        step();
        req_b = 1'b1;
        sb_q.push_back(predict(m_lfsr_b, 16'h0080, 7));
        rc = cyc;
        step();
        req_b = 1'b0;
        chk("b_busy", 32'(busy_b), 32'd1);
        n = 0;
        while (load_b !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("b_load_seen", 32'(load_b), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("b_lat_model", 32'(cyc - rc), 32'(e.lat));
        chk("b_lat", 32'(cyc - rc), 32'd10);
        chk("b_map", 32'(map_b), 32'(e.map));
        chk("b_fallback", 32'({map_b, type_b, bonus_b}), 32'({7'b0011100, 7'b0011100, 7'b0000000}));
        step();
        chk("b_start", 32'({start_b, load_b}), 32'b10);

        // LFSR sequence against the reference model
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("lfsr_seq", 32'(dut_a.u_row_gen.lfsr_q), 32'(m_lfsr_a));
        end
        chk("idle_quiet", 32'({busy_a, done_a, load_a}), 32'd0);

        // Single pulse request
        tick_en = 1'b1;
        req_a = 1'b1;
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        step();
        req_a = 1'b0;
        chk("s1_busy", 32'(busy_a), 32'd1);
        run_scroll("s1", rc, 0, 1'b0);
        step();
        chk("s1_rows", 32'(rows_a), 32'd1);
        chk("s1_idle", 32'(busy_a), 32'd0);

`ifdef SCROLL_CTRL_PENDING_EN
        req_a = 1'b1;
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        step();
        req_a = 1'b0;
        run_scroll("s2", rc, 0, 1'b1);
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        step();
        chk("pend_busy", 32'(busy_a), 32'd1);
        run_scroll("s3", rc, 0, 1'b0);
        step();
        chk("pend_end_idle", 32'(busy_a), 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("pend_no_third", 32'({busy_a, load_a}), 32'd0);
        chk("pend_rows", 32'(rows_a), 32'd3);
`else
        req_a = 1'b1;
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        run_scroll("s2", rc, 0, 1'b0);
        step();
        chk("held_gap", 32'({busy_a, done_a}), 32'd0);
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        run_scroll("s3", rc, 0, 1'b0);
        step();
        chk("held_gap2", 32'(busy_a), 32'd0);
        req_a = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("held_stop", 32'({busy_a, load_a}), 32'd0);
        chk("held_rows", 32'(rows_a), 32'd3);
`endif

        // Reset in the middle of the wait phase
        req_a = 1'b1;
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        step();
        req_a = 1'b0;
        run_scroll("ab", rc, 75, 1'b0);
        chk("ab_ticks", 32'(ticks), 32'd75);
        #2;
        rst = 1'b1;
        #1;
        chk("ab_ctrl", 32'({busy_a, load_a, start_a, done_a}), 32'd0);
        chk("ab_row", 32'({map_a, type_a, bonus_a}), 32'd0);
        chk("ab_rows", 32'(rows_a), 32'd0);
        chk("ab_lfsr", 32'(dut_a.u_row_gen.lfsr_q), 32'h0000ACE1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("ab_quiet", 32'(bad), 32'd0);
        req_a = 1'b1;
        sb_q.push_back(predict(m_lfsr_a, 16'hACE1, 2));
        rc = cyc;
        step();
        req_a = 1'b0;
        run_scroll("s5", rc, 0, 1'b0);
        step();
        chk("s5_rows", 32'(rows_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
Sequencer for the five scrolling layer instances of the playfield.
- On a scroll request it generates a new top row (block map, block type, bonus map).
- It drives a one-cycle load pulse, then a one-cycle start pulse, shared by all layers.
- It counts the scroll duration in 1 ms ticks, waits for the layers' end cycle, then reports completion to the game FSM.
- It sits between the game FSM and the layer stack.

Parameters:
SCROLL_MS, 150, number of one_ms_tick pulses a layer scroll lasts (a layer moves 150 px at 1 px/ms)
MIN_BLOCKS, 2, minimum number of set bits in a generated row map (range 1..7)
MAX_TRIES, 8, generation attempts before the fallback row is used
SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  pixel/system clock
rst  in  1  reset, asynchronous, active-high
one_ms_tick  in  1  single-cycle 1 ms strobe
scroll_req  in  1  request one row scroll (level or pulse; sampled in IDLE)
scroll_busy  out  1  high from request acceptance until scroll_done
layer_load  out  1  one-cycle pulse: layers latch row inputs
layer_start  out  1  one-cycle pulse: layers begin scrolling
scroll_done  out  1  one-cycle pulse when scroll is complete
new_map  out  [0:6]  generated block map for the top layer
new_type  out  [0:6]  generated block type (1 = ground, 0 = cloud)
new_bonus  out  [0:6]  generated bonus map, always a subset of new_map
rows_scrolled  out  16  count of completed scrolls; saturates at 16'hFFFF

Behaviour:
- All registers are reset asynchronously by rst.
  - Reset values: state IDLE; all pulses 0; scroll_busy 0; new_* 0; rows_scrolled 0; LFSR = SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Free-running, advances every clock in every state.
  - If the LFSR value is ever 0, the next value is SEED.
- Candidate row, formed each cycle from the LFSR: map = lfsr[6:0], type = lfsr[13:7], bonus = map & lfsr[15:9] & lfsr[12:6].
- States:
  - IDLE: when scroll_req=1, go to GEN, clear the try counter, set scroll_busy=1 (visible the next cycle).
  - GEN: one candidate per cycle.
    - If popcount(map) >= MIN_BLOCKS, register the candidate to new_* and go to LOAD.
    - Otherwise increment the try counter.
    - On the MAX_TRIES-th failure, register the fallback row (map 7'b0011100, type 7'b0011100, bonus 0) and go to LOAD.
  - LOAD: layer_load=1 for exactly one cycle; go to START.
  - START: layer_start=1 for exactly one cycle; clear the tick counter; go to WAIT.
  - WAIT: count one_ms_tick pulses.
    - On the SCROLL_MS-th tick go to SETTLE.
    - A tick arriving in the same cycle as START is not counted.
  - SETTLE: hold 2 cycles to cover the layers' end/reload cycle; go to DONE.
  - DONE: scroll_done=1 for one cycle; rows_scrolled+1 (saturating); scroll_busy=0 from the next cycle; go to IDLE.
- Pulse separation: layer_load and layer_start are never high together; start follows load by exactly 1 cycle.
- new_* hold their value from GEN completion until the next GEN completion.
- scroll_req outside IDLE is ignored unless the optional feature is enabled.
- Latency:
  - request to layer_load: 2 + number of failed tries cycles (minimum 2).
  - Last tick to scroll_done: 3 cycles.
- rst asserted mid-scroll: immediate return to IDLE, all outputs to reset values; the next scroll starts only on a new request.

Optional Feature:
SCROLL_CTRL_PENDING_EN
- Defined: a scroll_req seen while scroll_busy=1 sets a one-deep pending flag; further requests while pending are dropped.
  - In DONE with pending set: clear the flag, go directly to GEN, scroll_busy stays 1.
  - scroll_done still pulses for each scroll.
- Undefined: requests outside IDLE are discarded; no pending flag exists.

Decomposition:
- Shared package/macros header holds:
  - ROW_W=7 and LAYER_COUNT=5
  - SCROLL_MS default and fallback row constants
  - state encoding (3-bit: IDLE, GEN, LOAD, START, WAIT, SETTLE, DONE)
- One sub-module: row_gen (LFSR, candidate row formation, popcount >= MIN_BLOCKS compare).
- The FSM and counters stay in scroll_ctrl.

Test Plan:
- Reset with SEED default, no request -> all outputs 0, FSM idle; LFSR sequence matches the reference model for 20 cycles.
- Single scroll_req pulse, ticks every 10 clk -> layer_load then layer_start on consecutive cycles; scroll_done 3 cycles after the 150th counted tick; rows_scrolled=1; new_bonus & ~new_map == 0.
- Force LFSR (SEED=16'h0080) so the first candidates fail MIN_BLOCKS=7 -> fallback row 0011100/0011100/0000000 after 8 tries; layer_load at cycle 10 after request.
- scroll_req held high continuously, feature off -> back-to-back scrolls, each separated by one IDLE cycle; extra mid-scroll pulses ignored; rows_scrolled increments once per scroll.
- SCROLL_CTRL_PENDING_EN defined, two extra requests during WAIT -> exactly one additional scroll with no IDLE gap; scroll_busy stays high throughout; two scroll_done pulses total.
- rst asserted during WAIT (tick 75) -> all outputs 0 asynchronously; no scroll_done; next request restarts the full 150-tick sequence.
